breakout_rx: RTL and testbench
==============================

# breakout_rx

Host-side deserializer for the breakout link. It oversamples the three-wire breakout serial stream (frame clock, d0, d1) on the local clock and recovers each 10-bit frame. Each frame carries the 8-bit digital port, 6 buttons and 4 link-power flags, which the block presents as registered parallel words with a one-cycle valid strobe. It sits between the breakout link pins and the host register/stream logic, and reports lock and framing errors.

## Interface

Parameters:

- OVERSAMPLE, 4: local clock cycles per serial bit-time; even, ≥4.
- LOCK_FRAMES, 4: consecutive good frames required before lock asserts.

Ports:

- i_clk  in  1  local clock, OVERSAMPLE × serial bit rate.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clk_s  in  1  serial frame clock (10 bit-times per frame, high 5 / low 5).
- i_d0_s  in  1  serial lane 0.
- i_d1_s  in  1  serial lane 1.
- o_port  out  8  digital port word.
- o_button  out  6  button states.
- o_link_pow  out  4  link power flags.
- o_valid  out  1  one-cycle strobe when new outputs are written.
- o_locked  out  1  link locked.
- o_frame_err  out  1  one-cycle strobe on a framing error.
- o_changed  out  1  present only with BREAKOUT_RX_CHANGE_EN.

Reset value of every output is 0.

## Operation

- Input conditioning: all three serial inputs pass through 2-FF synchronizers, followed by one extra register on i_clk_s for edge detection.
- Frame boundary: a rising edge of synchronized i_clk_s. Bit k (k = 0..9, LSB first) on each lane is sampled OVERSAMPLE·k + OVERSAMPLE/2 cycles after the edge-detect cycle.
- Lane 0 word mapping: bits[1:0] are padding and are ignored; bits[7:2] → o_button[5:0]; bits[9:8] → o_link_pow[1:0].
- Lane 1 word mapping: bits[7:0] → o_port[7:0]; bits[9:8] → o_link_pow[3:2].
- State HUNT: wait for a rising edge, then go to SHIFT. The sample counter clears.
- State SHIFT: count cycles and capture 10 bits per lane at the sample points. After bit 9 is captured, go to CHECK.
- State CHECK: wait for the next rising edge.
  - Edge at cycle count 10·OVERSAMPLE ±1 from the previous edge: the frame is good. Outputs update, o_valid pulses, the good-frame counter increments (saturating at LOCK_FRAMES), the counter restarts from this edge, and the state returns to SHIFT.
  - Edge earlier than 10·OVERSAMPLE−1, or no edge by 10·OVERSAMPLE+1: the frame is discarded. o_frame_err pulses, the good-frame counter clears, and o_locked deasserts. An early edge restarts SHIFT from that edge; a timeout goes to HUNT.
- Frame-clock shape check: i_clk_s must be low at sample points 5..9. A high sample there is a framing error, handled like an early edge (frame discarded, error pulse, counter cleared).
- Lock: o_locked asserts in the cycle the good-frame counter reaches LOCK_FRAMES. It stays asserted until a framing error or reset.
- Output gating: outputs update on every good frame, including before lock. Consumers gate on o_locked.
- Reset mid-frame: all state returns to HUNT immediately and outputs go to 0. The first edge after reset release starts a frame.
- Simultaneous events: an edge arriving in the same cycle as a timeout counts as the edge.

## Timing

- o_valid is asserted for 1 cycle, in the cycle after the closing edge is detected. It never pulses on consecutive cycles. Its steady rate is one pulse per 10·OVERSAMPLE cycles.
- o_port, o_button and o_link_pow change only in the cycle o_valid is high, and hold otherwise.
- Latency: 3 cycles from the closing i_clk_s edge at the pin to o_valid high (2 synchronizer cycles + 1 edge-detect/output register cycle).
- o_frame_err is a 1-cycle strobe, registered in the cycle the error is determined.
- Counter width: ceil(log2(10·OVERSAMPLE+2)) bits. It never wraps, because the timeout fires first.

## Configuration

- BREAKOUT_RX_CHANGE_EN defined: adds port o_changed. It is a 1-cycle strobe coincident with o_valid, asserted when the new {o_link_pow, o_button, o_port} differs from the previously held value. The first frame after reset compares against zero.
- BREAKOUT_RX_CHANGE_EN undefined: the o_changed port and its comparison register are absent. All other behaviour is identical.

## Test plan

- Reset, then send 4 ideal frames with port=0xA5, button=0x2A, link_pow=0x9 → 4 o_valid pulses 40 cycles apart with those values; o_locked rises with the 4th pulse.
- Locked link, one frame closed by an edge at cycle 36 → o_frame_err pulse, o_locked low, no o_valid, outputs hold previous values; the next 4 good frames re-lock.
- Stop i_clk_s while locked → o_frame_err exactly 41 cycles after the last edge, state HUNT, o_locked low.
- Frame-period jitter of ±1 cycle alternating over 20 frames → no errors; every frame decodes correctly.
- Assert i_rst_n low mid-SHIFT → all outputs 0 asynchronously; after release, the first frame decodes correctly and o_locked stays low until 4 good frames.
- With BREAKOUT_RX_CHANGE_EN: send frames with port 0x00, 0x00, 0x01 → o_changed 0, 0, 1; with button=0 and link_pow=0, the first frame also gives o_changed 0.

Source files
------------

// File: rtl/breakout_rx.sv
// breakout_rx: host-side deserializer for the three-wire breakout link.
// Oversamples the frame clock and two data lanes on i_clk, recovers each
// 10-bit frame (LSB first) and presents port/button/link-power words with a
// one-cycle valid strobe, plus lock and framing-error status.
//
// Optional feature macro: BREAKOUT_RX_CHANGE_EN adds o_changed.
//
// Ports:
//   i_clk        local clock, OVERSAMPLE x serial bit rate
//   i_rst_n      asynchronous active-low reset
//   i_clk_s      serial frame clock (high 5 / low 5 bit-times)
//   i_d0_s       serial lane 0 (pad[1:0], button[5:0], link_pow[1:0])
//   i_d1_s       serial lane 1 (port[7:0], link_pow[3:2])
//   o_port       digital port word
//   o_button     button states
//   o_link_pow   link power flags
//   o_valid      one-cycle strobe when outputs are written
//   o_locked     LOCK_FRAMES consecutive good frames seen
//   o_frame_err  one-cycle strobe on a discarded frame
//   o_changed    strobe with o_valid when the decoded word differs
//                (BREAKOUT_RX_CHANGE_EN only)
//
// state | meaning
// HUNT  | idle, waiting for a frame-clock rising edge
// SHIFT | counting cycles, capturing bits 0..9 at mid-bit sample points
// CHECK | all bits captured, waiting for the closing edge or timeout
module breakout_rx #(
    parameter int OVERSAMPLE  = 4,
    parameter int LOCK_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clk_s,
    input  logic       i_d0_s,
    input  logic       i_d1_s,
    output logic [7:0] o_port,
    output logic [5:0] o_button,
    output logic [3:0] o_link_pow,
    output logic       o_valid,
    output logic       o_locked,
    output logic       o_frame_err
`ifdef BREAKOUT_RX_CHANGE_EN
   ,output logic       o_changed
`endif
);

    localparam int FRAME_LEN = 10 * OVERSAMPLE;
    localparam int CW        = $clog2(FRAME_LEN + 2);
    localparam int GW        = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] EDGE_MIN  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] EDGE_MAX  = CW'(FRAME_LEN + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_FRAMES - 1);
    localparam logic [GW-1:0] LOCK_FULL = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {HUNT, SHIFT, CHECK} state_t;

    logic [1:0]    clk_pipe, d0_pipe, d1_pipe;
    logic          clk_sync, clk_dly, d0_sync, d1_sync, rise;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, sample_pt;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sr0_q;  // lane 0 bits 9..2; the two pad bits shift out
    logic [9:0]    sr1_q;
    logic [GW-1:0] good_q;
    logic          sample, frame_good, frame_err;

    assign clk_sync  = clk_pipe[1];
    assign d0_sync   = d0_pipe[1];
    assign d1_sync   = d1_pipe[1];
    assign rise      = clk_sync & ~clk_dly;
    assign sample_pt = CW'(OVERSAMPLE / 2) + CW'(bit_q) * CW'(OVERSAMPLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_pipe <= '0;
            d0_pipe  <= '0;
            d1_pipe  <= '0;
            clk_dly  <= 1'b0;
        end else begin
            clk_pipe <= {clk_pipe[0], i_clk_s};
            d0_pipe  <= {d0_pipe[0], i_d0_s};
            d1_pipe  <= {d1_pipe[0], i_d1_s};
            clk_dly  <= clk_sync;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // cnt_q reads N in the Nth cycle after the edge-detect cycle.
    // An edge always wins over a sample point or timeout in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        sample     = 1'b0;
        frame_good = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            HUNT: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (rise) begin
                    // early edge: drop the frame and restart from this edge
                    frame_err = 1'b1;
                    cnt_d     = CW'(1);
                    bit_d     = '0;
                end else if (cnt_q == sample_pt) begin
                    if (bit_q >= 4'd5 && clk_sync) begin
                        // frame clock must be low over bits 5..9
                        frame_err = 1'b1;
                        state_d   = HUNT;
                        cnt_d     = '0;
                    end else begin
                        sample = 1'b1;
                        if (bit_q == 4'd9) state_d = CHECK;
                        else               bit_d   = bit_q + 4'd1;
                    end
                end
            end
            CHECK: begin
                if (rise) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                    bit_d   = '0;
                    if (cnt_q >= EDGE_MIN) frame_good = 1'b1;
                    else                   frame_err  = 1'b1;
                end else if (cnt_q >= EDGE_MAX) begin
                    frame_err = 1'b1;
                    state_d   = HUNT;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr0_q       <= '0;
            sr1_q       <= '0;
            good_q      <= '0;
            o_port      <= '0;
            o_button    <= '0;
            o_link_pow  <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= frame_good;
            o_frame_err <= frame_err;
            if (sample) begin
                sr0_q <= {d0_sync, sr0_q[7:1]};
                sr1_q <= {d1_sync, sr1_q[9:1]};
            end
            if (frame_err) begin
                good_q   <= '0;
                o_locked <= 1'b0;
            end else if (frame_good) begin
                o_port     <= sr1_q[7:0];
                o_button   <= sr0_q[5:0];
                o_link_pow <= {sr1_q[9:8], sr0_q[7:6]};
                if (good_q != LOCK_FULL) good_q <= good_q + GW'(1);
                if (good_q >= LOCK_LAST) o_locked <= 1'b1;
            end
        end
    end

`ifdef BREAKOUT_RX_CHANGE_EN
    // The held outputs are the previous word, so no extra copy is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_changed <= 1'b0;
        else          o_changed <= frame_good &&
                                   ({sr1_q[9:8], sr0_q[7:6], sr0_q[5:0], sr1_q[7:0]} !=
                                    {o_link_pow, o_button, o_port});
    end
`endif

endmodule

// File: tb/tb_breakout_rx.sv
module tb_breakout_rx;

    localparam int OS = 4;

    logic       clk, rst_n, clk_s, d0_s, d1_s;
    logic [7:0] port;
    logic [5:0] button;
    logic [3:0] link_pow;
    logic       valid, locked, frame_err, changed;

    breakout_rx #(.OVERSAMPLE(OS), .LOCK_FRAMES(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clk_s     (clk_s),
        .i_d0_s      (d0_s),
        .i_d1_s      (d1_s),
        .o_port      (port),
        .o_button    (button),
        .o_link_pow  (link_pow),
        .o_valid     (valid),
        .o_locked    (locked),
        .o_frame_err (frame_err)
`ifdef BREAKOUT_RX_CHANGE_EN
       ,.o_changed   (changed)
`endif
    );

`ifndef BREAKOUT_RX_CHANGE_EN
    assign changed = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] port;
        logic [5:0] btn;
        logic [3:0] pow;
        logic       locked;
        logic       changed;
        int         gap;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_seen = 0;
    int err_cyc = 0;
    int last_valid_cyc = 0;

    // model state
    int         good_m = 0;
    logic       locked_m = 1'b0;
    logic       chain = 1'b0;
    logic [17:0] prev_m = '0;
    logic       pend_valid = 1'b0;
    logic [7:0] pend_port;
    logic [5:0] pend_btn;
    logic [3:0] pend_pow;
    int         pend_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (frame_err) begin
            err_seen++;
            err_cyc = cyc;
        end
        if (valid) begin
            if (sb.size() == 0) begin
                chk("valid_unexp", 32'(valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("port", 32'(port), 32'(e.port));
                chk("button", 32'(button), 32'(e.btn));
                chk("link_pow", 32'(link_pow), 32'(e.pow));
                chk("locked", 32'(locked), 32'(e.locked));
`ifdef BREAKOUT_RX_CHANGE_EN
                chk("changed", 32'(changed), 32'(e.changed));
`endif
                if (e.gap != 0) chk("valid_gap", 32'(cyc - last_valid_cyc), 32'(e.gap));
            end
            last_valid_cyc = cyc;
        end
    end

    task automatic model_clear();
        good_m   = 0;
        locked_m = 1'b0;
        chain    = 1'b0;
    endtask

    task automatic push_pending();
        exp_t e;
        if (good_m < 4) good_m++;
        if (good_m == 4) locked_m = 1'b1;
        e.port    = pend_port;
        e.btn     = pend_btn;
        e.pow     = pend_pow;
        e.locked  = locked_m;
        e.changed = ({pend_pow, pend_btn, pend_port} != prev_m);
        e.gap     = chain ? pend_len : 0;
        prev_m    = {pend_pow, pend_btn, pend_port};
        chain     = 1'b1;
        sb.push_back(e);
    endtask

    task automatic drive_frame(input logic [9:0] lane0, input logic [9:0] lane1, input int len);
        int rem = len;
        for (int k = 0; k < 10; k++) begin
            int n;
            n = (k == 9) ? rem : ((rem < OS) ? rem : OS);
            rem -= n;
            clk_s = (k < 5);
            d0_s  = lane0[k];
            d1_s  = lane1[k];
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Starting a frame closes the previous one, so its expectation is pushed now.
    task automatic send_frame(input logic [7:0] p, input logic [5:0] b, input logic [3:0] w,
                              input int len, input logic good);
        logic [1:0] pad;
        pad = 2'($urandom);
        if (pend_valid) push_pending();
        pend_valid = good;
        pend_port  = p;
        pend_btn   = b;
        pend_pow   = w;
        pend_len   = len;
        drive_frame({w[1:0], b, pad}, {w[3:2], p}, len);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clk_s = 1'b0;
        d0_s  = 1'b0;
        d1_s  = 1'b0;
        sb.delete();
        pend_valid = 1'b0;
        prev_m = '0;
        model_clear();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        clk_s = 1'b0;
        d0_s  = 1'b0;
        d1_s  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_port", 32'(port), 32'd0);
        chk("rst_button", 32'(button), 32'd0);
        chk("rst_pow", 32'(link_pow), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_changed", 32'(changed), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // ideal frames, lock on the 4th
        for (int i = 0; i < 5; i++) send_frame(8'hA5, 6'h2A, 4'h9, 40, 1'b1);

        // early closing edge at cycle 36
        e0 = err_seen;
        send_frame(8'h3C, 6'h11, 4'h6, 36, 1'b0);
        model_clear();
        send_frame(8'h0F, 6'h3F, 4'hF, 40, 1'b1);
        chk("early_err", 32'(err_seen - e0), 32'd1);
        chk("early_unlock", 32'(locked), 32'd0);
        chk("hold_port", 32'(port), 32'hA5);
        chk("hold_button", 32'(button), 32'h2A);
        chk("hold_pow", 32'(link_pow), 32'h9);
        for (int i = 0; i < 4; i++) send_frame(8'(8'h10 + i), 6'(i), 4'(i + 3), 40, 1'b1);

        // +/-1 cycle jitter over 20 frames
        e0 = err_seen;
        for (int i = 0; i < 20; i++)
            send_frame(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)),
                       4'($urandom_range(0, 15)), (i % 2 == 0) ? 39 : 41, 1'b1);
        chk("jitter_err", 32'(err_seen - e0), 32'd0);
        chk("jitter_lock", 32'(locked), 32'd1);

        // stop the frame clock while locked
        e0 = err_seen;
        pend_valid = 1'b0;
        model_clear();
        clk_s = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("timeout_err", 32'(err_seen - e0), 32'd1);
        chk("timeout_delay", 32'(err_cyc - last_valid_cyc), 32'd41);
        chk("timeout_unlock", 32'(locked), 32'd0);

        // re-lock from HUNT, then reset in the middle of SHIFT
        for (int i = 0; i < 5; i++) send_frame(8'h5A, 6'h15, 4'h6, 40, 1'b1);
        send_frame(8'hFF, 6'h3F, 4'hF, 14, 1'b0);
        chk("pre_rst_lock", 32'(locked), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_port", 32'(port), 32'd0);
        chk("async_button", 32'(button), 32'd0);
        chk("async_pow", 32'(link_pow), 32'd0);
        chk("async_locked", 32'(locked), 32'd0);
        do_reset();
        for (int i = 0; i < 5; i++) send_frame(8'hC3, 6'h11, 4'h5, 40, 1'b1);

        // change detection: port 0, 0, 1 with zero buttons/power
        do_reset();
        send_frame(8'h00, 6'h00, 4'h0, 40, 1'b1);
        send_frame(8'h00, 6'h00, 4'h0, 40, 1'b1);
        send_frame(8'h01, 6'h00, 4'h0, 40, 1'b1);
        send_frame(8'h01, 6'h00, 4'h0, 40, 1'b0);
        clk_s = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
